// File: rtl/ALUSrcA_pkg.sv
// ALUSrcA_pkg: datapath source-A mux select shared by control and datapath
package ALUSrcA_pkg;
  typedef enum logic {FROM_REGFILE = 1'b0, FROM_PC = 1'b1} ALUSrcA_t;
endpackage

// File: rtl/rv32i_ctrl_pkg.sv
// rv32i_ctrl_pkg: states, datapath select encodings, opcodes and per-state Moore outputs
package rv32i_ctrl_pkg;
  import ALUSrcA_pkg::*;
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_READ, S_MEM_WB, S_MEM_WRITE, S_EXEC_R, S_EXEC_I,
    S_LUI, S_ALU_WB, S_BRANCH, S_JALR_ADDR, S_JUMP_LINK, S_PC_NEXT, S_TRAP
  } state_t;
  typedef enum logic [1:0] {SRCB_REG = 2'd0, SRCB_IMM = 2'd1, SRCB_FOUR = 2'd2} ALUSrcB_t;
  typedef enum logic [1:0] {ALU_ADD = 2'd0, ALU_SUB = 2'd1, ALU_FUNCT = 2'd2, ALU_PASS_B = 2'd3} ALUOp_t;
  typedef enum logic [1:0] {RES_ALUOUT = 2'd0, RES_MEMDATA = 2'd1, RES_ALURESULT = 2'd2} ResultSrc_t;
  typedef enum logic {PC_ALURESULT = 1'b0, PC_ALUOUT = 1'b1} PCSrc_t;
  typedef enum logic {ADR_PC = 1'b0, ADR_ALUOUT = 1'b1} AdrSrc_t;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  typedef struct packed {
    ALUSrcA_t   alu_src_a;
    ALUSrcB_t   alu_src_b;
    ALUOp_t     alu_op;
    ResultSrc_t result_src;
    PCSrc_t     pc_src;
    AdrSrc_t    adr_src;
    logic       reg_write;
    logic       mem_req;
    logic       mem_we;
    logic       pc_write;
    logic       illegal;
  } ctrl_t;
  function automatic ctrl_t moore(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: c.mem_req = 1'b1;
      S_DECODE: begin c.alu_src_a = FROM_PC; c.alu_src_b = SRCB_IMM; end
      S_MEM_ADDR, S_JALR_ADDR: c.alu_src_b = SRCB_IMM;
      S_MEM_READ: begin c.adr_src = ADR_ALUOUT; c.mem_req = 1'b1; end
      S_MEM_WB: begin c.result_src = RES_MEMDATA; c.reg_write = 1'b1; end
      S_MEM_WRITE: begin c.adr_src = ADR_ALUOUT; c.mem_req = 1'b1; c.mem_we = 1'b1; end
      S_EXEC_R: c.alu_op = ALU_FUNCT;
      S_EXEC_I: begin c.alu_src_b = SRCB_IMM; c.alu_op = ALU_FUNCT; end
      S_LUI: begin c.alu_src_b = SRCB_IMM; c.alu_op = ALU_PASS_B; end
      S_ALU_WB: c.reg_write = 1'b1;
      S_BRANCH: begin c.alu_op = ALU_SUB; c.pc_src = PC_ALUOUT; end
      S_JUMP_LINK: begin
        c.alu_src_a = FROM_PC; c.alu_src_b = SRCB_FOUR; c.result_src = RES_ALURESULT;
        c.reg_write = 1'b1; c.pc_write = 1'b1; c.pc_src = PC_ALUOUT;
      end
      S_PC_NEXT: begin c.alu_src_a = FROM_PC; c.alu_src_b = SRCB_FOUR; c.pc_write = 1'b1; end
      S_TRAP: c.illegal = 1'b1;
      default: ;
    endcase
    return c;
  endfunction
endpackage

// File: rtl/rv32i_branch_cond.sv
// rv32i_branch_cond: branch taken decision from funct3 and ALU compare flags
module rv32i_branch_cond (
  input  logic [2:0] funct3,
  input  logic       alu_zero,
  input  logic       alu_lt,
  input  logic       alu_ltu,
  output logic       taken,
  output logic       invalid
);
  logic flag;
  // funct3[2:1] picks the flag, funct3[0] inverts it; 010/011 are unused encodings
  always_comb begin
    invalid = funct3[2:1] == 2'b01;
    flag = funct3[2] ? (funct3[1] ? alu_ltu : alu_lt) : alu_zero;
    taken = ~invalid & (flag ^ funct3[0]);
  end
endmodule

// File: rtl/rv32i_multicycle_ctrl.sv
// rv32i_multicycle_ctrl: multicycle RV32I main control FSM driving datapath selects and strobes
module rv32i_multicycle_ctrl
  import ALUSrcA_pkg::*, rv32i_ctrl_pkg::*;
#(
  parameter int ENABLE_TRAP = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       alu_zero,
  input  logic       alu_lt,
  input  logic       alu_ltu,
  input  logic       mem_ready,
  output ALUSrcA_t   alu_src_a,
  output ALUSrcB_t   alu_src_b,
  output ALUOp_t     alu_op,
  output ResultSrc_t result_src,
  output PCSrc_t     pc_src,
  output AdrSrc_t    adr_src,
  output logic       pc_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       mem_req,
  output logic       mem_we,
  output logic       retire,
  output logic       illegal
);
  localparam state_t BAD = (ENABLE_TRAP != 0) ? S_TRAP : S_PC_NEXT;
  state_t state, nxt;
  ctrl_t ctrl_q;
  logic taken, invalid;
  rv32i_branch_cond u_cond (
    .funct3(funct3), .alu_zero(alu_zero), .alu_lt(alu_lt), .alu_ltu(alu_ltu),
    .taken(taken), .invalid(invalid)
  );
  // next-state sequencing; memory states wait on mem_ready, TRAP waits for reset
  always_comb begin
    nxt = state;
    case (state)
      S_FETCH: nxt = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE:
        case (opcode)
          OP_LOAD, OP_STORE: nxt = S_MEM_ADDR;
          OP_R:              nxt = S_EXEC_R;
          OP_I:              nxt = S_EXEC_I;
          OP_BRANCH:         nxt = S_BRANCH;
          OP_JAL:            nxt = S_JUMP_LINK;
          OP_JALR:           nxt = S_JALR_ADDR;
          OP_LUI:            nxt = S_LUI;
          OP_AUIPC:          nxt = S_ALU_WB;
          default:           nxt = BAD;
        endcase
      S_MEM_ADDR: nxt = opcode == OP_LOAD ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ: nxt = mem_ready ? S_MEM_WB : S_MEM_READ;
      S_MEM_WRITE: nxt = mem_ready ? S_PC_NEXT : S_MEM_WRITE;
      S_MEM_WB, S_ALU_WB: nxt = S_PC_NEXT;
      S_EXEC_R, S_EXEC_I, S_LUI: nxt = S_ALU_WB;
      S_BRANCH: nxt = invalid ? BAD : taken ? S_FETCH : S_PC_NEXT;
      S_JALR_ADDR: nxt = S_JUMP_LINK;
      S_JUMP_LINK, S_PC_NEXT: nxt = S_FETCH;
      S_TRAP: nxt = S_TRAP;
      default: nxt = S_FETCH;
    endcase
  end
  // state and Moore outputs registered together so outputs come straight from flops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_FETCH;
      ctrl_q <= moore(S_FETCH);
    end else begin
      state <= nxt;
      ctrl_q <= moore(nxt);
    end
  end
  assign alu_src_a = ctrl_q.alu_src_a;
  assign alu_src_b = ctrl_q.alu_src_b;
  assign alu_op = ctrl_q.alu_op;
  assign result_src = ctrl_q.result_src;
  assign pc_src = ctrl_q.pc_src;
  assign adr_src = ctrl_q.adr_src;
  assign reg_write = ctrl_q.reg_write & ~rst;
  assign mem_req = ctrl_q.mem_req & ~rst;
  assign mem_we = ctrl_q.mem_we & ~rst;
  assign illegal = ctrl_q.illegal & ~rst;
  assign ir_write = ~rst & (state == S_FETCH) & mem_ready;
  assign pc_write = ~rst & (ctrl_q.pc_write | ((state == S_BRANCH) & taken));
  assign retire = pc_write;
endmodule

// File: tb/tb_rv32i_multicycle_ctrl.sv
// tb_rv32i_multicycle_ctrl: directed checks of the multicycle control FSM outputs
module tb_rv32i_multicycle_ctrl;
  import ALUSrcA_pkg::*;
  import rv32i_ctrl_pkg::*;
  logic clk = 1'b0;
  logic rst, alu_zero, alu_lt, alu_ltu, mem_ready;
  logic [6:0] opcode;
  logic [2:0] funct3;
  ALUSrcA_t alu_src_a;
  ALUSrcB_t alu_src_b;
  ALUOp_t alu_op;
  ResultSrc_t result_src;
  PCSrc_t pc_src;
  AdrSrc_t adr_src;
  logic pc_write, ir_write, reg_write, mem_req, mem_we, retire, illegal;
  int total = 0;
  int bad = 0;
  logic [15:0] obs;
  rv32i_multicycle_ctrl #(.ENABLE_TRAP(1)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .alu_zero(alu_zero),
    .alu_lt(alu_lt), .alu_ltu(alu_ltu), .mem_ready(mem_ready), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .result_src(result_src), .pc_src(pc_src),
    .adr_src(adr_src), .pc_write(pc_write), .ir_write(ir_write), .reg_write(reg_write),
    .mem_req(mem_req), .mem_we(mem_we), .retire(retire), .illegal(illegal)
  );
  always #5 clk = ~clk;
  assign obs = {alu_src_a, alu_src_b, alu_op, result_src, pc_src, adr_src,
                pc_write, ir_write, reg_write, mem_req, mem_we, retire, illegal};
  // strobes: {pc_write, ir_write, reg_write, mem_req, mem_we, retire, illegal}
  function automatic logic [15:0] mk(input logic a, input logic [1:0] b, input logic [1:0] op,
                                     input logic [1:0] res, input logic pcs, input logic adr,
                                     input logic [6:0] s);
    return {a, b, op, res, pcs, adr, s};
  endfunction
  localparam logic [15:0] E_RST     = 16'h0000;
  localparam logic [15:0] E_FETCH_R = {1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 7'b0101000};
  localparam logic [15:0] E_FETCH_W = {1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 7'b0001000};
  localparam logic [15:0] E_DECODE  = {1'b1, 2'd1, 2'd0, 2'd0, 1'b0, 1'b0, 7'b0000000};
  localparam logic [15:0] E_EXEC_R  = {1'b0, 2'd0, 2'd2, 2'd0, 1'b0, 1'b0, 7'b0000000};
  localparam logic [15:0] E_EXEC_I  = {1'b0, 2'd1, 2'd2, 2'd0, 1'b0, 1'b0, 7'b0000000};
  localparam logic [15:0] E_LUI     = {1'b0, 2'd1, 2'd3, 2'd0, 1'b0, 1'b0, 7'b0000000};
  localparam logic [15:0] E_ALU_WB  = {1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 7'b0010000};
  localparam logic [15:0] E_PC_NEXT = {1'b1, 2'd2, 2'd0, 2'd0, 1'b0, 1'b0, 7'b1000010};
  localparam logic [15:0] E_MADDR   = {1'b0, 2'd1, 2'd0, 2'd0, 1'b0, 1'b0, 7'b0000000};
  localparam logic [15:0] E_MREAD   = {1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b1, 7'b0001000};
  localparam logic [15:0] E_MEM_WB  = {1'b0, 2'd0, 2'd0, 2'd1, 1'b0, 1'b0, 7'b0010000};
  localparam logic [15:0] E_MWRITE  = {1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b1, 7'b0001100};
  localparam logic [15:0] E_BR_T    = {1'b0, 2'd0, 2'd1, 2'd0, 1'b1, 1'b0, 7'b1000010};
  localparam logic [15:0] E_BR_NT   = {1'b0, 2'd0, 2'd1, 2'd0, 1'b1, 1'b0, 7'b0000000};
  localparam logic [15:0] E_JADDR   = {1'b0, 2'd1, 2'd0, 2'd0, 1'b0, 1'b0, 7'b0000000};
  localparam logic [15:0] E_JLINK   = {1'b1, 2'd2, 2'd0, 2'd2, 1'b1, 1'b0, 7'b1010010};
  localparam logic [15:0] E_TRAP    = {1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 7'b0000001};
  task automatic chk(input string tag, input logic [15:0] e);
    total++;
    assert (obs === e) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, e);
    end
  endtask
  task automatic cyc(input string tag, input logic [15:0] e);
    @(negedge clk);
    chk(tag, e);
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst = 1'b1; opcode = 7'd0; funct3 = 3'd0; alu_zero = 1'b0; alu_lt = 1'b0;
    alu_ltu = 1'b0; mem_ready = 1'b0;
    @(posedge clk);
    #1;
    chk("reset_hold", E_RST);
    rst = 1'b0; mem_ready = 1'b1; opcode = OP_R;
    cyc("add_fetch", E_FETCH_R);
    cyc("add_decode", E_DECODE);
    cyc("add_exec_r", E_EXEC_R);
    cyc("add_alu_wb", E_ALU_WB);
    cyc("add_pc_next", E_PC_NEXT);
    opcode = OP_LOAD;
    cyc("lw_fetch", E_FETCH_R);
    cyc("lw_decode", E_DECODE);
    mem_ready = 1'b0;
    cyc("lw_mem_addr", E_MADDR);
    cyc("lw_wait1", E_MREAD);
    cyc("lw_wait2", E_MREAD);
    cyc("lw_wait3", E_MREAD);
    mem_ready = 1'b1;
    cyc("lw_ready", E_MREAD);
    cyc("lw_mem_wb", E_MEM_WB);
    cyc("lw_pc_next", E_PC_NEXT);
    opcode = OP_BRANCH; funct3 = 3'b000; alu_zero = 1'b1;
    cyc("beq_t_fetch", E_FETCH_R);
    cyc("beq_t_decode", E_DECODE);
    cyc("beq_taken", E_BR_T);
    alu_zero = 1'b0;
    cyc("beq_nt_fetch", E_FETCH_R);
    cyc("beq_nt_decode", E_DECODE);
    cyc("beq_not_taken", E_BR_NT);
    cyc("beq_pc_next", E_PC_NEXT);
    funct3 = 3'b110; alu_ltu = 1'b1;
    cyc("bltu_fetch", E_FETCH_R);
    cyc("bltu_decode", E_DECODE);
    cyc("bltu_taken", E_BR_T);
    funct3 = 3'b101; alu_lt = 1'b1; alu_ltu = 1'b0;
    cyc("bge_fetch", E_FETCH_R);
    cyc("bge_decode", E_DECODE);
    cyc("bge_not_taken", E_BR_NT);
    cyc("bge_pc_next", E_PC_NEXT);
    alu_lt = 1'b0;
    opcode = OP_JALR;
    cyc("jalr_fetch", E_FETCH_R);
    cyc("jalr_decode", E_DECODE);
    cyc("jalr_addr", E_JADDR);
    cyc("jalr_link", E_JLINK);
    opcode = OP_JAL;
    cyc("jal_fetch", E_FETCH_R);
    cyc("jal_decode", E_DECODE);
    cyc("jal_link", E_JLINK);
    opcode = OP_LUI;
    cyc("lui_fetch", E_FETCH_R);
    cyc("lui_decode", E_DECODE);
    cyc("lui_exec", E_LUI);
    cyc("lui_alu_wb", E_ALU_WB);
    cyc("lui_pc_next", E_PC_NEXT);
    opcode = OP_AUIPC;
    cyc("auipc_fetch", E_FETCH_R);
    cyc("auipc_decode", E_DECODE);
    cyc("auipc_alu_wb", E_ALU_WB);
    cyc("auipc_pc_next", E_PC_NEXT);
    opcode = OP_I;
    cyc("addi_fetch", E_FETCH_R);
    cyc("addi_decode", E_DECODE);
    cyc("addi_exec_i", E_EXEC_I);
    cyc("addi_alu_wb", E_ALU_WB);
    cyc("addi_pc_next", E_PC_NEXT);
    opcode = OP_STORE;
    cyc("sw_fetch", E_FETCH_R);
    cyc("sw_decode", E_DECODE);
    mem_ready = 1'b0;
    cyc("sw_mem_addr", E_MADDR);
    cyc("sw_wait1", E_MWRITE);
    rst = 1'b1;
    #1;
    chk("sw_rst_drop", E_RST);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc("sw_after_rst_fetch", E_FETCH_W);
    mem_ready = 1'b1;
    cyc("sw2_fetch", E_FETCH_R);
    cyc("sw2_decode", E_DECODE);
    cyc("sw2_mem_addr", E_MADDR);
    cyc("sw2_write", E_MWRITE);
    cyc("sw2_pc_next", E_PC_NEXT);
    opcode = 7'b1111111;
    cyc("bad_fetch", E_FETCH_R);
    cyc("bad_decode", E_DECODE);
    for (int i = 0; i < 10; i++) cyc("trap_hold", E_TRAP);
    rst = 1'b1;
    #1;
    chk("trap_rst_async", E_RST);
    @(posedge clk);
    #1;
    rst = 1'b0;
    opcode = OP_BRANCH; funct3 = 3'b010; alu_zero = 1'b1;
    cyc("badbr_fetch", E_FETCH_R);
    cyc("badbr_decode", E_DECODE);
    cyc("badbr_branch", E_BR_NT);
    cyc("badbr_trap", E_TRAP);
    cyc("badbr_trap_hold", E_TRAP);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
